// File: rtl/disp_arb_pkg.sv
// Shared encodings and helpers for the seven-segment display share arbiter.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int         NREQ      = 4;
  localparam logic [3:0] BLANK_ALL = 4'b1111;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requests, searching from ptr+1 so
// the requester at ptr is considered last.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] win
);

  logic [3:0] rot;

  // rot[k] is the request k+1 positions after ptr
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot[gi] = req[2'(ptr + 2'(gi + 1))];
  end

  assign any = |req;

  always_comb begin
    win = 2'(ptr + 2'd1);
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) win = 2'(ptr + 2'(k + 1));
    end
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin sharing of the four-digit display with a minimum hold time per
// owner and an all-blank gap between owners; all outputs are registered.
module disp_share_arbiter
  import disp_arb_pkg::*;
#(
  parameter int HOLD_BITS = 24,
  parameter int GAP_BITS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  input  logic [3:0]  blk0,
  input  logic [3:0]  blk1,
  input  logic [3:0]  blk2,
  input  logic [3:0]  blk3,
  output logic [3:0]  grant,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  blank,
  output logic [1:0]  owner,
  output logic        busy
);

  state_t               state_reg, state_next;
  logic [HOLD_BITS-1:0] hold_cnt_reg, hold_cnt_next;
  logic [GAP_BITS-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [1:0]           rr_ptr_reg, rr_ptr_next;
  logic [1:0]           owner_next;
  logic                 pick_any;
  logic [1:0]           pick_win;
  logic                 expired;
  logic                 others;
  logic [15:0]          val_arr [NREQ];
  logic [3:0]           blk_arr [NREQ];

  assign val_arr[0] = val0;
  assign val_arr[1] = val1;
  assign val_arr[2] = val2;
  assign val_arr[3] = val3;
  assign blk_arr[0] = blk0;
  assign blk_arr[1] = blk1;
  assign blk_arr[2] = blk2;
  assign blk_arr[3] = blk3;

  rr_pick4 u_pick (
    .req (req),
    .ptr (rr_ptr_reg),
    .any (pick_any),
    .win (pick_win)
  );

  assign expired = &hold_cnt_reg;
  assign others  = |(req & ~onehot(owner));

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner;
    hold_cnt_next = hold_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          state_next    = ST_OWN;
          owner_next    = pick_win;
          hold_cnt_next = '0;
        end
      end
      ST_OWN: begin
        if (!expired) hold_cnt_next = hold_cnt_reg + 1'b1;
        // Owner dropping out wins over the hold guarantee
        if (!req[owner] || (expired && others)) begin
          state_next   = ST_GAP;
          gap_cnt_next = '0;
          rr_ptr_next  = owner;
        end
      end
      ST_GAP: begin
        gap_cnt_next = gap_cnt_reg + 1'b1;
        if (&gap_cnt_reg) begin
          if (pick_any) begin
            state_next    = ST_OWN;
            owner_next    = pick_win;
            hold_cnt_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      rr_ptr_reg   <= 2'd3;
      grant        <= '0;
      {A, B, C, D} <= '0;
      blank        <= BLANK_ALL;
      owner        <= 2'd0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
      // Outputs follow the next state so the first OWN cycle already shows data
      if (state_next == ST_OWN) begin
        grant        <= onehot(owner_next);
        {A, B, C, D} <= val_arr[owner_next];
        blank        <= blk_arr[owner_next];
        owner        <= owner_next;
        busy         <= 1'b1;
      end else begin
        grant <= '0;
        blank <= BLANK_ALL;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed-vector bench for disp_share_arbiter with short hold and gap times.
module tb_disp_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [15:0] vals [4];
  logic [3:0]  blks [4];
  logic [3:0]  grant, A, B, C, D, blank;
  logic [1:0]  owner;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  disp_share_arbiter #(.HOLD_BITS(4), .GAP_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .val0  (vals[0]),
    .val1  (vals[1]),
    .val2  (vals[2]),
    .val3  (vals[3]),
    .blk0  (blks[0]),
    .blk1  (blks[1]),
    .blk2  (blks[2]),
    .blk3  (blks[3]),
    .grant (grant),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .blank (blank),
    .owner (owner),
    .busy  (busy)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  cyc;
    logic [3:0]  eg;
    logic [3:0]  eb;
    logic [15:0] ed;
    logic [1:0]  eo;
    logic        ebz;
  } vec_t;

  vec_t vecs [15];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int id, input logic [3:0] eg,
                       input logic [3:0] eb, input logic [15:0] ed,
                       input logic [1:0] eo, input logic ebz);
    logic [30:0] act, exp;
    act = {grant, blank, A, B, C, D, owner, busy};
    exp = {eg, eb, ed, eo, ebz};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got grant=%b blank=%b digits=%h owner=%0d busy=%b, want grant=%b blank=%b digits=%h owner=%0d busy=%b",
               name, id, grant, blank, {A, B, C, D}, owner, busy, eg, eb, ed, eo, ebz);
    end else begin
      $display("ok   %s #%0d: grant=%b blank=%b digits=%h owner=%0d busy=%b",
               name, id, grant, blank, {A, B, C, D}, owner, busy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  g1;
    logic [15:0] ev;
    vals[0] = 16'h0123; vals[1] = 16'h4567; vals[2] = 16'h1234; vals[3] = 16'hCDEF;
    blks[0] = 4'b0000;  blks[1] = 4'b0000;  blks[2] = 4'b0000;  blks[3] = 4'b0101;

    //          rst   req      cyc   grant    blank    digits    own    busy
    vecs[0]  = {1'b1, 4'b0000, 8'd1, 4'b0000, 4'b1111, 16'h0000, 2'd0, 1'b0};
    vecs[1]  = {1'b0, 4'b0100, 8'd1, 4'b0100, 4'b0000, 16'h1234, 2'd2, 1'b1};
    vecs[2]  = {1'b0, 4'b0100, 8'd2, 4'b0100, 4'b0000, 16'h1234, 2'd2, 1'b1};
    vecs[3]  = {1'b0, 4'b0000, 8'd1, 4'b0000, 4'b1111, 16'h1234, 2'd2, 1'b0};
    vecs[4]  = {1'b0, 4'b0000, 8'd3, 4'b0000, 4'b1111, 16'h1234, 2'd2, 1'b0};
    vecs[5]  = {1'b0, 4'b0000, 8'd1, 4'b0000, 4'b1111, 16'h1234, 2'd2, 1'b0};
    vecs[6]  = {1'b0, 4'b0001, 8'd1, 4'b0001, 4'b0000, 16'h0123, 2'd0, 1'b1};
    vecs[7]  = {1'b1, 4'b0001, 8'd1, 4'b0000, 4'b1111, 16'h0000, 2'd0, 1'b0};
    vecs[8]  = {1'b0, 4'b0001, 8'd1, 4'b0001, 4'b0000, 16'h0123, 2'd0, 1'b1};
    vecs[9]  = {1'b0, 4'b0000, 8'd1, 4'b0000, 4'b1111, 16'h0123, 2'd0, 1'b0};
    vecs[10] = {1'b1, 4'b1000, 8'd1, 4'b0000, 4'b1111, 16'h0000, 2'd0, 1'b0};
    vecs[11] = {1'b0, 4'b1001, 8'd1, 4'b0001, 4'b0000, 16'h0123, 2'd0, 1'b1};
    vecs[12] = {1'b0, 4'b0000, 8'd1, 4'b0000, 4'b1111, 16'h0123, 2'd0, 1'b0};
    vecs[13] = {1'b1, 4'b0000, 8'd1, 4'b0000, 4'b1111, 16'h0000, 2'd0, 1'b0};
    vecs[14] = {1'b0, 4'b1000, 8'd1, 4'b1000, 4'b0101, 16'hCDEF, 2'd3, 1'b1};

    step(2);
    for (int i = 0; i < 15; i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      step(int'(vecs[i].cyc));
      check("table", i, vecs[i].eg, vecs[i].eb, vecs[i].ed, vecs[i].eo, vecs[i].ebz);
    end

    // Hold for 16 cycles with a waiting requester, 4 blank cycles, then hand off to 1
    do_reset();
    req = 4'b0100;
    step(1);
    req = 4'b0110;
    for (int c = 0; c < 16; c++) begin
      check("hold", c, 4'b0100, 4'b0000, vals[2], 2'd2, 1'b1);
      step(1);
    end
    for (int c = 0; c < 4; c++) begin
      check("gap", c, 4'b0000, 4'b1111, vals[2], 2'd2, 1'b0);
      step(1);
    end
    check("handoff", 0, 4'b0010, 4'b0000, vals[1], 2'd1, 1'b1);

    // All four requesting: full rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      g1 = 4'b0001 << (k % 4);
      for (int c = 0; c < 16; c++) begin
        check("rr_own", k * 100 + c, g1, blks[k % 4], vals[k % 4], 2'(k % 4), 1'b1);
        step(1);
      end
      if (k < 4) begin
        for (int c = 0; c < 4; c++) begin
          check("rr_gap", k * 100 + c, 4'b0000, 4'b1111, vals[k % 4], 2'(k % 4), 1'b0);
          step(1);
        end
      end
    end

    // Sole requester keeps the display; a value change shows one cycle later
    do_reset();
    req = 4'b0010;
    step(1);
    for (int c = 0; c < 100; c++) begin
      ev = (c > 50) ? 16'h9ABC : 16'h4567;
      check("sole", c, 4'b0010, 4'b0000, ev, 2'd1, 1'b1);
      if (c == 50) vals[1] = 16'h9ABC;
      step(1);
    end
    vals[1] = 16'h4567;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
